// File: rtl/seq_mult_gen_if.sv
// Start/done handshake and operand/result bus for the iterative shift-add multiplier.
// The requester drives the operands; the multiplier returns busy, done and the product.
interface seq_mult_gen_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] P;

  modport master (output start, sgn, x, y, input busy, done, P);
  modport slave  (input start, sgn, x, y, output busy, done, P);
endinterface

// File: rtl/seq_mult_gen.sv
// Iterative shift-add multiplier: one partial-product row per clock, result after WIDTH+1 cycles.
// Signed mode multiplies magnitudes and negates the final product when the operand signs differ.
module seq_mult_gen #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  seq_mult_gen_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]         state_r;
  logic [CW-1:0]      count_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               neg_r;
  logic               busy_r;
  logic               done_r;
  logic [2*WIDTH-1:0] p_r;
  logic [WIDTH:0]     sum_s;

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is still correct read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    if (s && v[WIDTH-1]) begin
      mag = (~v) + WIDTH'(1);
    end else begin
      mag = v;
    end
  endfunction

  // Upper-half accumulate of the current partial-product row.
  always_comb begin
    sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    if (mplier_r[0]) begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      count_r  <= {CW{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      p_r      <= {(2*WIDTH){1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            mcand_r  <= mag(bus.x, bus.sgn);
            mplier_r <= mag(bus.y, bus.sgn);
            neg_r    <= bus.sgn & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
            acc_r    <= {(2*WIDTH){1'b0}};
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end
        end
        RUN: begin
          acc_r    <= {sum_s, acc_r[WIDTH-1:1]};
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + CW'(1);
          if (count_r == CW'(WIDTH - 1)) begin
            state_r <= FIN;
          end
        end
        FIN: begin
          p_r     <= neg_r ? -acc_r : acc_r;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.P    = p_r;
endmodule

// File: tb/tb_seq_mult_gen.sv
// Directed-vector bench for seq_mult_gen at WIDTH=8 and WIDTH=4 with hand-computed products.
module tb_seq_mult_gen;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   lat;
  int   bcnt;
  int   dcnt;

  seq_mult_gen_if #(.WIDTH(8)) bus8 ();
  seq_mult_gen_if #(.WIDTH(4)) bus4 ();

  seq_mult_gen #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  seq_mult_gen #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs and observations all happen 1ns after a rising edge.
  task automatic launch8(input logic s, input logic [7:0] a, input logic [7:0] b);
    bus8.start = 1'b1; bus8.sgn = s; bus8.x = a; bus8.y = b;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.sgn = ~s; bus8.x = 8'hA5; bus8.y = 8'h5A;
    check_val("busy8_after_start", {31'd0, bus8.busy}, 32'd1);
  endtask

  task automatic wait_done8(output int l, output int b);
    l = 0; b = 1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      l++;
      if (bus8.done) break;
      if (bus8.busy) b++;
    end
    if (!bus8.done) l = 99;
    check_val("busy8_at_done", {31'd0, bus8.busy}, 32'd0);
  endtask

  task automatic launch4(input logic s, input logic [3:0] a, input logic [3:0] b);
    bus4.start = 1'b1; bus4.sgn = s; bus4.x = a; bus4.y = b;
    @(posedge clk); #1;
    bus4.start = 1'b0; bus4.sgn = ~s; bus4.x = 4'h3; bus4.y = 4'hC;
  endtask

  task automatic wait_done4(output int l);
    l = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      l++;
      if (bus4.done) break;
    end
    if (!bus4.done) l = 99;
  endtask

  // One full WIDTH=8 operation with product and latency checks.
  task automatic op8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp);
    int l;
    int bc;
    launch8(s, a, b);
    wait_done8(l, bc);
    check_val({tag, "_lat"}, l, 32'd9);
    check_val({tag, "_P"}, {16'd0, bus8.P}, {16'd0, exp});
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    bus8.start = 1'b0; bus8.sgn = 1'b0; bus8.x = 8'h00; bus8.y = 8'h00;
    bus4.start = 1'b0; bus4.sgn = 1'b0; bus4.x = 4'h0; bus4.y = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", {31'd0, bus8.busy}, 32'd0);
    check_val("rst_done", {31'd0, bus8.done}, 32'd0);
    check_val("rst_P", {16'd0, bus8.P}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 2x2 with busy-length and one-cycle done checks
    launch8(1'b0, 8'h02, 8'h02);
    wait_done8(lat, bcnt);
    check_val("t1_lat", lat, 32'd9);
    check_val("t1_busy_cycles", bcnt, 32'd9);
    check_val("t1_P", {16'd0, bus8.P}, 32'h0004);
    @(posedge clk); #1;
    check_val("t1_done_pulse", {31'd0, bus8.done}, 32'd0);
    check_val("t1_P_held", {16'd0, bus8.P}, 32'h0004);

    op8("uFFxFF", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    op8("sFFxFF", 1'b1, 8'hFF, 8'hFF, 16'h0001);
    op8("s80x80", 1'b1, 8'h80, 8'h80, 16'h4000);
    op8("s80x01", 1'b1, 8'h80, 8'h01, 16'hFF80);
    op8("s00x80", 1'b1, 8'h00, 8'h80, 16'h0000);

    // start during busy is ignored; start in the done cycle is accepted
    launch8(1'b0, 8'h03, 8'h05);
    repeat (2) @(posedge clk);
    #1;
    bus8.start = 1'b1; bus8.x = 8'h10; bus8.y = 8'h10; bus8.sgn = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait_done8(lat, bcnt);
    check_val("b2b_first_lat", lat, 32'd6);
    check_val("b2b_first_P", {16'd0, bus8.P}, 32'h000F);
    op8("b2b_second", 1'b0, 8'h10, 8'h10, 16'h0100);

    // reset mid-operation aborts with no done pulse
    launch8(1'b0, 8'h09, 8'h09);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_busy", {31'd0, bus8.busy}, 32'd0);
    check_val("abort_done", {31'd0, bus8.done}, 32'd0);
    check_val("abort_P", {16'd0, bus8.P}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus8.done) dcnt++;
    end
    check_val("abort_no_done", dcnt, 32'd0);
    op8("after_abort", 1'b0, 8'h07, 8'h06, 16'h002A);

    // WIDTH=4 instance
    launch4(1'b0, 4'hF, 4'hF);
    wait_done4(lat);
    check_val("w4_u_lat", lat, 32'd5);
    check_val("w4_u_P", {24'd0, bus4.P}, 32'h00E1);
    launch4(1'b1, 4'h8, 4'h7);
    wait_done4(lat);
    check_val("w4_s_lat", lat, 32'd5);
    check_val("w4_s_P", {24'd0, bus4.P}, 32'h00C8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
